// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared encodings for the pipeline control path: ALU op codes, condition codes,
// instruction-class fields and the immediate/register-address select values.
package pipe_ctrl_unit_pkg;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_AND = 5'b00010,
        ALU_ORR = 5'b00011,
        ALU_EOR = 5'b00100,
        ALU_ADC = 5'b00101,
        ALU_SBC = 5'b00110,
        ALU_MOV = 5'b00111,
        ALU_MUL = 5'b01000
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] IMMSRC_DP  = 2'b00;
    localparam logic [1:0] IMMSRC_MEM = 2'b01;
    localparam logic [1:0] IMMSRC_BR  = 2'b10;

    // RegSrc[0] picks R15 for the first operand, RegSrc[1] picks Rd as the second.
    localparam logic [1:0] REGSRC_DEF = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_STR = 2'b10;
    localparam logic [1:0] REGSRC_MUL = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_SBC = 4'b0110;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    function automatic logic is_compare(input logic [3:0] cmd);
        return (cmd == CMD_TST) || (cmd == CMD_CMP) || (cmd == CMD_CMN);
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Bundle between the control unit (slave) and the datapath/hazard unit (master).
interface pipe_ctrl_unit_if #(
    parameter int ALUCONTROL_WIDTH = 5,
    parameter int ALU_FLAGS_WIDTH  = 5
);
    // No handshake: every signal is a per-cycle level; D signals belong to the
    // instruction in Decode this cycle, E/M/W signals to the one in that stage.
    logic [31:0]                 InstrD;
    logic [ALU_FLAGS_WIDTH-1:0]  ALUFlagsE;
    logic                        FlushE;
    logic [1:0]                  RegSrcD;
    logic [1:0]                  ImmSrcD;
    logic                        ALUSrcE;
    logic [ALUCONTROL_WIDTH-1:0] ALUControlE;
    logic                        CarryE;
    logic                        BranchTakenE;
    logic                        MemWriteM;
    logic                        MemtoRegE;
    logic                        MemtoRegW;
    logic                        RegWriteM;
    logic                        RegWriteW;
    logic                        PCSrcW;
    logic                        PCWrPendingF;

    modport master (
        output InstrD, ALUFlagsE, FlushE,
        input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, CarryE, BranchTakenE,
               MemWriteM, MemtoRegE, MemtoRegW, RegWriteM, RegWriteW, PCSrcW,
               PCWrPendingF
    );

    modport slave (
        input  InstrD, ALUFlagsE, FlushE,
        output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, CarryE, BranchTakenE,
               MemWriteM, MemtoRegE, MemtoRegW, RegWriteM, RegWriteW, PCSrcW,
               PCWrPendingF
    );
endinterface

// File: rtl/pipe_ctrl_unit_cond_check.sv
// Combinational ARM condition evaluation against the stored N,Z,C,V flags.
module pipe_ctrl_unit_cond_check
    import pipe_ctrl_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n, z, c, v, ge;

    assign {n, z, c, v} = flags;
    assign ge = (n == v);

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~(c & ~z);
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~z & ge;
            COND_LE: cond_ex = ~(~z & ge);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control path: decode in D, condition check and NZCV register in E, E/M/W control registers.
// Optional MUL decode is enabled by defining PIPE_CTRL_MUL_EN.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int ALUCONTROL_WIDTH = 5,
    parameter int ALU_FLAGS_WIDTH  = 5
)(
    input logic             clk,
    input logic             reset,
    pipe_ctrl_unit_if.slave bus
);
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond_d;

    logic       reg_write_d, mem_write_d, mem_to_reg_d, branch_d;
    logic       pcs_d, flag_write_d, alu_src_d;
    logic [1:0] reg_src_d, imm_src_d;
    alu_op_e    alu_control_d;

    logic                        reg_write_e, mem_write_e, mem_to_reg_e, branch_e;
    logic                        pcs_e, flag_write_e, alu_src_e;
    logic [ALUCONTROL_WIDTH-1:0] alu_control_e;
    logic [3:0]                  cond_e;
    logic                        cond_ex_e;
    logic [ALU_FLAGS_WIDTH-1:0]  flags_q;

    logic reg_write_m, mem_write_m, mem_to_reg_m, pcs_m;
    logic reg_write_w, mem_to_reg_w, pcs_w;
    logic unused_bits;

    assign op     = bus.InstrD[27:26];
    assign funct  = bus.InstrD[25:20];
    assign rd     = bus.InstrD[15:12];
    assign cond_d = bus.InstrD[31:28];

    always_comb begin
        reg_write_d   = 1'b0;
        mem_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
        branch_d      = 1'b0;
        flag_write_d  = 1'b0;
        alu_src_d     = 1'b0;
        reg_src_d     = REGSRC_DEF;
        imm_src_d     = IMMSRC_DP;
        alu_control_d = ALU_ADD;
        case (op)
            OP_DP: begin
                alu_src_d    = funct[5];
                reg_write_d  = ~is_compare(funct[4:1]);
                flag_write_d = funct[0] | is_compare(funct[4:1]);
                case (funct[4:1])
                    CMD_AND, CMD_TST: alu_control_d = ALU_AND;
                    CMD_EOR:          alu_control_d = ALU_EOR;
                    CMD_SUB, CMD_CMP: alu_control_d = ALU_SUB;
                    CMD_ADD, CMD_CMN: alu_control_d = ALU_ADD;
                    CMD_ADC:          alu_control_d = ALU_ADC;
                    CMD_SBC:          alu_control_d = ALU_SBC;
                    CMD_ORR:          alu_control_d = ALU_ORR;
                    CMD_MOV:          alu_control_d = ALU_MOV;
                    default: begin
                        // Unassigned opcodes retire without side effects.
                        reg_write_d  = 1'b0;
                        flag_write_d = 1'b0;
                    end
                endcase
`ifdef PIPE_CTRL_MUL_EN
                if (bus.InstrD[7:4] == 4'b1001) begin
                    alu_control_d = ALU_MUL;
                    reg_src_d     = REGSRC_MUL;
                    alu_src_d     = 1'b0;
                    reg_write_d   = 1'b1;
                    flag_write_d  = funct[0];
                end
`else
`endif
            end
            OP_MEM: begin
                imm_src_d     = IMMSRC_MEM;
                alu_src_d     = ~funct[5];
                alu_control_d = funct[3] ? ALU_ADD : ALU_SUB;
                if (funct[0]) begin
                    mem_to_reg_d = 1'b1;
                    reg_write_d  = 1'b1;
                end else begin
                    mem_write_d = 1'b1;
                    reg_src_d   = REGSRC_STR;
                end
            end
            OP_BR: begin
                branch_d  = 1'b1;
                alu_src_d = 1'b1;
                reg_src_d = REGSRC_BR;
                imm_src_d = IMMSRC_BR;
            end
            default: ;
        endcase
    end

    assign pcs_d = ((rd == 4'hF) & reg_write_d) | branch_d;

    always_ff @(posedge clk) begin
        if (reset || bus.FlushE) begin
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            mem_to_reg_e  <= 1'b0;
            branch_e      <= 1'b0;
            pcs_e         <= 1'b0;
            flag_write_e  <= 1'b0;
            alu_src_e     <= 1'b0;
            alu_control_e <= '0;
            cond_e        <= 4'b0000;
        end else begin
            reg_write_e   <= reg_write_d;
            mem_write_e   <= mem_write_d;
            mem_to_reg_e  <= mem_to_reg_d;
            branch_e      <= branch_d;
            pcs_e         <= pcs_d;
            flag_write_e  <= flag_write_d;
            alu_src_e     <= alu_src_d;
            alu_control_e <= ALUCONTROL_WIDTH'(alu_control_d);
            cond_e        <= cond_d;
        end
    end

    pipe_ctrl_unit_cond_check u_cond_check (
        .cond    (cond_e),
        .flags   (flags_q[3:0]),
        .cond_ex (cond_ex_e)
    );

    // Flags belong to the instruction leaving E, so FlushE never blocks the update.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (flag_write_e && cond_ex_e) begin
            flags_q <= bus.ALUFlagsE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            pcs_m        <= 1'b0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            pcs_w        <= 1'b0;
        end else begin
            reg_write_m  <= reg_write_e & cond_ex_e;
            mem_write_m  <= mem_write_e & cond_ex_e;
            mem_to_reg_m <= mem_to_reg_e;
            // A branch redirects the PC from E; only R15 register writes travel on.
            pcs_m        <= pcs_e & cond_ex_e & ~branch_e;
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
            pcs_w        <= pcs_m;
        end
    end

    assign bus.RegSrcD      = reg_src_d;
    assign bus.ImmSrcD      = imm_src_d;
    assign bus.ALUSrcE      = alu_src_e;
    assign bus.ALUControlE  = alu_control_e;
    assign bus.CarryE       = flags_q[1];
    assign bus.BranchTakenE = branch_e & cond_ex_e;
    assign bus.MemWriteM    = mem_write_m;
    assign bus.MemtoRegE    = mem_to_reg_e;
    assign bus.MemtoRegW    = mem_to_reg_w;
    assign bus.RegWriteM    = reg_write_m;
    assign bus.RegWriteW    = reg_write_w;
    assign bus.PCSrcW       = pcs_w;
    assign bus.PCWrPendingF = pcs_d | pcs_e | pcs_m;

    assign unused_bits = ^{bus.InstrD[19:16], bus.InstrD[11:0],
                           flags_q[ALU_FLAGS_WIDTH-1:4]};
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: hand-encoded ARM instructions with hand-derived stage outputs.
module tb_pipe_ctrl_unit;
    localparam logic [31:0] NOP    = 32'hEC000000;
    localparam logic [31:0] ADD    = 32'hE0821003;
    localparam logic [31:0] SUBS   = 32'hE0500000;
    localparam logic [31:0] ADDS   = 32'hE0900000;
    localparam logic [31:0] ADDEQ  = 32'h02844001;
    localparam logic [31:0] ADDNE  = 32'h12844001;
    localparam logic [31:0] BEQ    = 32'h0A000000;
    localparam logic [31:0] LDR    = 32'hE5915004;
    localparam logic [31:0] STR    = 32'hE5015004;
    localparam logic [31:0] CMP    = 32'hE3500000;
    localparam logic [31:0] SUB    = 32'hE0411001;
    localparam logic [31:0] ADDPC  = 32'hE080F001;
    localparam logic [31:0] ADDNV  = 32'hF0821003;
    localparam logic [31:0] MULPAT = 32'hE0010392;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_alu_mul;
    logic [31:0] exp_regsrc_mul;

    pipe_ctrl_unit_if #(.ALUCONTROL_WIDTH(5), .ALU_FLAGS_WIDTH(5)) bus ();

    pipe_ctrl_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then present the next D instruction, the ALU flags for
    // the instruction now in E, and the flush request for the coming edge.
    task automatic cyc(input logic [31:0] instr, input logic [4:0] flags, input logic flush);
        @(posedge clk);
        #1;
        bus.InstrD    = instr;
        bus.ALUFlagsE = flags;
        bus.FlushE    = flush;
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {13'd0, bus.RegSrcD, bus.ImmSrcD, bus.ALUSrcE, bus.ALUControlE, bus.CarryE,
                bus.BranchTakenE, bus.MemWriteM, bus.MemtoRegE, bus.MemtoRegW,
                bus.RegWriteM, bus.RegWriteW, bus.PCSrcW, bus.PCWrPendingF};
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
`ifdef PIPE_CTRL_MUL_EN
        exp_alu_mul    = 32'h08;
        exp_regsrc_mul = 32'h3;
`else
        exp_alu_mul    = 32'h02;
        exp_regsrc_mul = 32'h0;
`endif
        reset = 1'b1;
        bus.InstrD    = NOP;
        bus.ALUFlagsE = 5'b0;
        bus.FlushE    = 1'b0;
        cyc(NOP, 5'b0, 1'b0);
        cyc(NOP, 5'b0, 1'b0);
        chk("reset_outputs", all_outs(), 32'h0);
        reset = 1'b0;

        // ADD R1,R2,R3 down the pipe
        cyc(ADD, 5'b0, 1'b0);
        chk("add_regsrc_d", bus.RegSrcD, 32'h0);
        chk("add_immsrc_d", bus.ImmSrcD, 32'h0);
        chk("add_pcwr_d", bus.PCWrPendingF, 32'h0);
        cyc(NOP, 5'b0, 1'b0);
        chk("add_aluctl_e", bus.ALUControlE, 32'h00);
        chk("add_alusrc_e", bus.ALUSrcE, 32'h0);
        chk("add_regwr_m_early", bus.RegWriteM, 32'h0);
        cyc(NOP, 5'b0, 1'b0);
        chk("add_regwr_m", bus.RegWriteM, 32'h1);
        cyc(NOP, 5'b0, 1'b0);
        chk("add_regwr_w", bus.RegWriteW, 32'h1);
        chk("add_pcsrc_w", bus.PCSrcW, 32'h0);

        // SUBS sets Z; ADDEQ executes, ADDNE does not
        cyc(SUBS, 5'b0, 1'b0);
        cyc(ADDEQ, 5'b00100, 1'b0);
        chk("subs_aluctl_e", bus.ALUControlE, 32'h01);
        cyc(NOP, 5'b0, 1'b0);
        chk("addeq_alusrc_e", bus.ALUSrcE, 32'h1);
        chk("addeq_aluctl_e", bus.ALUControlE, 32'h00);
        chk("z_flags_carry", bus.CarryE, 32'h0);
        cyc(NOP, 5'b0, 1'b0);
        chk("addeq_regwr_m", bus.RegWriteM, 32'h1);
        cyc(ADDNE, 5'b0, 1'b0);
        cyc(NOP, 5'b0, 1'b0);
        cyc(NOP, 5'b0, 1'b0);
        chk("addne_regwr_m", bus.RegWriteM, 32'h0);

        // BEQ not taken: ADDS leaves Z=0, C=1
        cyc(ADDS, 5'b0, 1'b0);
        cyc(BEQ, 5'b00010, 1'b0);
        chk("beq_regsrc_d", bus.RegSrcD, 32'h1);
        chk("beq_immsrc_d", bus.ImmSrcD, 32'h2);
        chk("beq_pcwr_d", bus.PCWrPendingF, 32'h1);
        cyc(NOP, 5'b0, 1'b0);
        chk("beq_nt_taken_e", bus.BranchTakenE, 32'h0);
        chk("adds_carry", bus.CarryE, 32'h1);
        chk("beq_nt_pcwr_e", bus.PCWrPendingF, 32'h1);
        cyc(NOP, 5'b0, 1'b0);
        chk("beq_nt_pcwr_m", bus.PCWrPendingF, 32'h0);

        // BEQ taken: SUBS sets Z=1
        cyc(SUBS, 5'b0, 1'b0);
        cyc(BEQ, 5'b00100, 1'b0);
        chk("beq_t_pcwr_d", bus.PCWrPendingF, 32'h1);
        cyc(NOP, 5'b0, 1'b0);
        chk("beq_t_taken_e", bus.BranchTakenE, 32'h1);
        chk("beq_t_pcwr_e", bus.PCWrPendingF, 32'h1);
        chk("beq_t_alusrc_e", bus.ALUSrcE, 32'h1);
        cyc(NOP, 5'b0, 1'b0);
        chk("beq_t_pcwr_m", bus.PCWrPendingF, 32'h0);
        chk("beq_t_taken_m", bus.BranchTakenE, 32'h0);
        cyc(NOP, 5'b0, 1'b0);
        chk("beq_t_pcsrc_w", bus.PCSrcW, 32'h0);

        // LDR followed by STR
        cyc(LDR, 5'b0, 1'b0);
        chk("ldr_regsrc_d", bus.RegSrcD, 32'h0);
        chk("ldr_immsrc_d", bus.ImmSrcD, 32'h1);
        cyc(STR, 5'b0, 1'b0);
        chk("str_regsrc_d", bus.RegSrcD, 32'h2);
        chk("ldr_memtoreg_e", bus.MemtoRegE, 32'h1);
        chk("ldr_aluctl_e", bus.ALUControlE, 32'h00);
        chk("ldr_alusrc_e", bus.ALUSrcE, 32'h1);
        cyc(NOP, 5'b0, 1'b0);
        chk("ldr_regwr_m", bus.RegWriteM, 32'h1);
        chk("ldr_memwr_m", bus.MemWriteM, 32'h0);
        chk("str_aluctl_e", bus.ALUControlE, 32'h01);
        chk("str_memtoreg_e", bus.MemtoRegE, 32'h0);
        cyc(NOP, 5'b0, 1'b0);
        chk("ldr_regwr_w", bus.RegWriteW, 32'h1);
        chk("ldr_memtoreg_w", bus.MemtoRegW, 32'h1);
        chk("str_memwr_m", bus.MemWriteM, 32'h1);
        chk("str_regwr_m", bus.RegWriteM, 32'h0);
        cyc(NOP, 5'b0, 1'b0);
        chk("str_regwr_w", bus.RegWriteW, 32'h0);

        // Write to R15 travels to W; never-condition suppresses writes
        cyc(ADDPC, 5'b0, 1'b0);
        chk("addpc_pcwr_d", bus.PCWrPendingF, 32'h1);
        cyc(NOP, 5'b0, 1'b0);
        chk("addpc_pcwr_e", bus.PCWrPendingF, 32'h1);
        cyc(NOP, 5'b0, 1'b0);
        chk("addpc_pcwr_m", bus.PCWrPendingF, 32'h1);
        cyc(NOP, 5'b0, 1'b0);
        chk("addpc_pcsrc_w", bus.PCSrcW, 32'h1);
        chk("addpc_pcwr_w", bus.PCWrPendingF, 32'h0);
        cyc(ADDNV, 5'b0, 1'b0);
        cyc(NOP, 5'b0, 1'b0);
        cyc(NOP, 5'b0, 1'b0);
        chk("addnv_regwr_m", bus.RegWriteM, 32'h0);

        // CMP flushed on its D->E edge: no flag update, bubble downstream
        cyc(CMP, 5'b0, 1'b1);
        cyc(NOP, 5'b00010, 1'b0);
        chk("flush_aluctl_e", bus.ALUControlE, 32'h00);
        chk("flush_alusrc_e", bus.ALUSrcE, 32'h0);
        chk("flush_memtoreg_e", bus.MemtoRegE, 32'h0);
        cyc(NOP, 5'b0, 1'b0);
        chk("flush_carry", bus.CarryE, 32'h0);
        chk("flush_regwr_m", bus.RegWriteM, 32'h0);
        chk("flush_memwr_m", bus.MemWriteM, 32'h0);
        cyc(NOP, 5'b0, 1'b0);
        chk("flush_regwr_w", bus.RegWriteW, 32'h0);
        chk("flush_pcsrc_w", bus.PCSrcW, 32'h0);

        // CMP in E while FlushE bubbles the SUB behind it
        cyc(CMP, 5'b0, 1'b0);
        cyc(SUB, 5'b00010, 1'b1);
        chk("cmp_aluctl_e", bus.ALUControlE, 32'h01);
        chk("cmp_alusrc_e", bus.ALUSrcE, 32'h1);
        cyc(NOP, 5'b0, 1'b0);
        chk("cmp_flush_carry", bus.CarryE, 32'h1);
        chk("sub_bubble_aluctl_e", bus.ALUControlE, 32'h00);
        chk("cmp_regwr_m", bus.RegWriteM, 32'h0);
        cyc(NOP, 5'b0, 1'b0);
        chk("sub_bubble_regwr_m", bus.RegWriteM, 32'h0);

        // Reset with instructions in flight
        cyc(ADD, 5'b0, 1'b0);
        cyc(ADDPC, 5'b0, 1'b0);
        cyc(NOP, 5'b0, 1'b0);
        chk("pre_reset_regwr_m", bus.RegWriteM, 32'h1);
        chk("pre_reset_pcwr", bus.PCWrPendingF, 32'h1);
        reset = 1'b1;
        cyc(NOP, 5'b0, 1'b0);
        chk("midstream_reset_outputs", all_outs(), 32'h0);
        reset = 1'b0;

        // Multiply pattern
        cyc(MULPAT, 5'b0, 1'b0);
        chk("mul_regsrc_d", bus.RegSrcD, exp_regsrc_mul);
        cyc(NOP, 5'b0, 1'b0);
        chk("mul_aluctl_e", bus.ALUControlE, exp_alu_mul);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Control path for the five-stage pipelined core: decodes the instruction held in the Decode stage and evaluates its condition field in Execute. Carries the resulting control bits through E/M/W pipeline registers, in lockstep with the datapath's data registers, and holds the architectural NZCV flags. Sits beside the datapath, supplying every D/E/M/W select, and reports pending writes to the hazard unit.

## Interface
Parameters:
- ALUCONTROL_WIDTH, 5, width of the ALU operation code.
- ALU_FLAGS_WIDTH, 5, width of ALU flag vector; bits [3:0] = N,Z,C,V, bit [4] captured but not used by conditions.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- InstrD  in  32  instruction in Decode stage.
- ALUFlagsE  in  ALU_FLAGS_WIDTH  flags produced by the ALU this cycle.
- FlushE  in  1  hazard unit: turn E-stage control into a bubble at next edge.
- RegSrcD  out  2  register-address selects.
- ImmSrcD  out  2  immediate-extension select.
- ALUSrcE  out  1  SrcB = immediate.
- ALUControlE  out  ALUCONTROL_WIDTH  ALU operation.
- CarryE  out  1  stored C flag, fed to ALU carry-in.
- BranchTakenE  out  1  branch resolved taken in E.
- MemWriteM  out  1  data-memory write strobe.
- MemtoRegE, MemtoRegW  out  1  result from memory (E copy for load-use detection).
- RegWriteM, RegWriteW  out  1  register-file write (M copy for forwarding).
- PCSrcW  out  1  write of R15 reaches W.
- PCWrPendingF  out  1  PC write in flight in D, E or M.

## Operation
- Decode (combinational on InstrD): Op=InstrD[27:26] selects data-processing (00), memory (01) or branch (10); 11 decodes as NOP (all write enables 0).
- Data-processing: ALUControl from Funct[4:1]: AND, EOR, SUB, ADD, ADC, SBC, ORR, MOV. CMP, TST and CMN write flags only, no register. FlagWrite = S bit (forced 1 for compares).
- Memory: ALU = ADD, or SUB when U bit clear. LDR sets MemtoReg and RegWrite; STR sets MemWrite and RegSrc[1].
- Branch: ALU = ADD, ALUSrc = 1, RegSrc[0] = 1, ImmSrc = 10.
- PCS = (Rd==15 & RegWrite) | Branch.
- D→E register captures RegWrite, MemWrite, MemtoReg, Branch, PCS, FlagWrite, ALUSrc, ALUControl and Cond. FlushE or reset clears all write-type bits; ALUControl clears to 0.
- Condition check in E: Cond (16 ARM codes, 1111 = never) against the stored flag register gives CondExE. Gated outputs are RegWrite, MemWrite, PCS and FlagWrite, each ANDed with CondExE. BranchTakenE = BranchE & CondExE.
- Flag register: updates at the E-stage edge when FlagWriteE & CondExE, capturing all ALU_FLAGS_WIDTH bits. It is not touched by FlushE, which only affects the instruction entering E.
- E→M and M→W registers carry the gated bits plus MemtoReg. BranchTakenE is not forwarded to PCSrc, so a branch writes the PC only through BranchTakenE.

## Timing
- Decode outputs have zero latency from InstrD.
- E outputs are valid 1 cycle after the instruction is in D; M after 2; W after 3.
- Flags written by instruction i are visible to the condition of i+1 in the next cycle; there is no same-cycle bypass.
- PCWrPendingF = PCSD | PCSE | PCSM, all ungated.
- Reset clears every register and output to 0, including flags. Reset mid-stream discards all in-flight control.
- FlushE and a flag-writing instruction in E in the same cycle: the flags update, and the next E is a bubble.

## Configuration
- PIPE_CTRL_MUL_EN defined: data-processing with InstrD[7:4]=1001 and Op=00 decodes as MUL, with ALUControl = 01000, operands Rn=InstrD[3:0] and Rm=InstrD[11:8] selected via RegSrc, and S bit honoured.
- Not defined: that pattern decodes as AND per Funct, with no MUL encoding present.

## Structure
- The shared package holds:
  - ALUControl encodings (ADD 00000, SUB 00001, AND 00010, ORR 00011, EOR 00100, ADC 00101, SBC 00110, MOV 00111, MUL 01000).
  - Cond codes.
  - Op field constants.
  - The ImmSrc and RegSrc constants.
- One sub-module, cond_check: combinational, taking Cond and the flags and producing CondEx.

## Test plan
- ADD R1,R2,R3 (E0821003) in D → ALUControlE=00000 at +1, RegWriteM=1 at +2, RegWriteW=1 at +3, PCSrcW=0.
- SUBS R0,R0,R0 then ADDEQ R4,R4,#1 → flags Z=1 latched; ADDEQ RegWriteM=1. Repeat with ADDNE → RegWriteM=0.
- BEQ with Z=0 → BranchTakenE=0. With Z=1 → BranchTakenE=1, PCWrPendingF high during the D and E cycles.
- LDR R5,[R1,#4] → MemtoRegE=1 and ALUControlE=00000 at +1, RegWriteW=1 and MemtoRegW=1 at +3; STR → MemWriteM=1 and RegWriteM=0.
- CMP with FlushE=1 on its D→E edge → flags unchanged, all E/M/W enables 0. Reset asserted mid-sequence → all outputs 0 next edge.
- With PIPE_CTRL_MUL_EN: E0010392 → ALUControlE=01000. Without it → 00010.
